// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, halt word and fetch state.
package inst_fetch_pkg;
  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int LUT_IDX_W = 3;
  localparam int CNT_W     = 16;

  localparam logic [INSTR_W-1:0] kHALT = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch_branch_lut.sv
// Relative-branch offset table: maps a 3-bit instruction field to a signed PC displacement.
module inst_fetch_branch_lut
  import inst_fetch_pkg::*;
(
  input  logic        [LUT_IDX_W-1:0] idx,
  output logic signed [PC_W-1:0]      offset
);

  always_comb begin
    offset = '0;
    case (idx)
      3'd0:    offset = 10'sd2;
      3'd1:    offset = 10'sd4;
      3'd2:    offset = 10'sd8;
      3'd3:    offset = -10'sd2;
      3'd4:    offset = -10'sd4;
      3'd5:    offset = -10'sd8;
      3'd6:    offset = 10'sd16;
      3'd7:    offset = -10'sd16;
      default: offset = '0;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC sequencing with relative branches and halt detection.
// Optional cycle counter output CycleCount is built when FETCH_PERF_CNT_EN is defined.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  input  logic [INSTR_W-1:0] InstrIn,
  input  logic               BranchRel,
  input  logic               Taken,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] Instruction,
  output logic               Valid,
  output logic               Done,
  output fetch_state_e       dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   CycleCount
`endif
);

  // Handshake: Start is a level request honoured only in IDLE/DONE (no ready back);
  // Valid is a pure qualifier, high for exactly the cycles the fetched word is live.

  fetch_state_e         state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      br_offset;
  logic                 start_acc;
  logic                 halt;

  assign start_acc = Start && (state_q != ST_RUN);
  assign halt      = (InstrIn == kHALT);

  inst_fetch_branch_lut u_lut (
    .idx    (InstrIn[LUT_IDX_W-1:0]),
    .offset (br_offset)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_RUN;
      ST_RUN:  if (halt)  state_d = ST_DONE;
      ST_DONE: if (Start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Valid     = (state_q == ST_RUN);
    Done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // Halt wins over a simultaneous taken branch: the PC freezes on the halt word.
  always_comb begin
    pc_d = pc_q;
    if (state_q == ST_RUN) begin
      if (!halt) begin
        if (BranchRel && Taken) pc_d = pc_q + br_offset;
        else                    pc_d = pc_q + 10'd1;
      end
    end else if (start_acc) begin
      pc_d = StartAddr;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC          = pc_q;
  assign Instruction = InstrIn;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (start_acc) begin
      cnt_q <= '0;
    end else if ((state_q == ST_RUN) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign CycleCount = cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random programs against a behavioural model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic         Clk;
  logic         Reset_n;
  logic         Start;
  logic [9:0]   StartAddr;
  logic [8:0]   InstrIn;
  logic         BranchRel;
  logic         Taken;
  logic [9:0]   PC;
  logic [8:0]   Instruction;
  logic         Valid;
  logic         Done;
  fetch_state_e dbg_state;
  logic [15:0]  CycleCount;

  logic [8:0]   rom [0:1023];
  assign InstrIn = rom[PC];

  inst_fetch dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .InstrIn     (InstrIn),
    .BranchRel   (BranchRel),
    .Taken       (Taken),
    .PC          (PC),
    .Instruction (Instruction),
    .Valid       (Valid),
    .Done        (Done),
    .dbg_state   (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .CycleCount  (CycleCount)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign CycleCount = 16'd0;
`endif

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // behavioural model: program position, running/finished flags, cycle count
  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  m_pc;
  bit          m_run, m_done;
  logic [15:0] m_cnt;
  int          offs [8] = '{2, 4, 8, -2, -4, -8, 16, -16};
  logic [36:0] exp_q [$];

  function automatic logic [9:0] wrap(input int v);
    return 10'(((v % 1024) + 1024) % 1024);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cycle(input bit st, input logic [9:0] sa, input bit br, input bit tk);
    logic [8:0] w;
    w = rom[m_pc];
    exp_q.push_back({m_pc, m_run, m_done, w, m_cnt});
    Start = st; StartAddr = sa; BranchRel = br; Taken = tk;
    if (m_run) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (w == 9'h1FF) begin
        m_run = 1'b0; m_done = 1'b1;
      end else if (br && tk) begin
        m_pc = wrap(int'(m_pc) + offs[w % 8]);
      end else begin
        m_pc = wrap(int'(m_pc) + 1);
      end
    end else if (st) begin
      m_pc = sa; m_run = 1'b1; m_done = 1'b0; m_cnt = 16'd0;
    end
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; Start = 1'b0; BranchRel = 1'b0; Taken = 1'b0;
    #1;
    check("rst_pc", PC, 0);
    check("rst_valid", Valid, 0);
    check("rst_done", Done, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_cnt", CycleCount, 0);
`endif
    m_pc = 10'd0; m_run = 1'b0; m_done = 1'b0; m_cnt = 16'd0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge Clk) begin
    logic [36:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_pc", PC, e[36:27]);
      check("sb_valid", Valid, e[26]);
      check("sb_done", Done, e[25]);
      check("sb_instr", Instruction, e[24:16]);
`ifdef FETCH_PERF_CNT_EN
      check("sb_cnt", CycleCount, e[15:0]);
`endif
    end
  end

  initial begin
    Reset_n = 1'b0; Start = 1'b0; StartAddr = '0; BranchRel = 1'b0; Taken = 1'b0;
    m_pc = 10'd0; m_run = 1'b0; m_done = 1'b0; m_cnt = 16'd0;
    for (int a = 0; a < 1024; a++)
      rom[a] = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
    for (int a = 16'h030; a < 16'h034; a++) rom[a] = 9'h000;
    rom[10'h3FE] = 9'h000; rom[10'h3FF] = 9'h000; rom[10'h000] = 9'h000;
    rom[10'h010] = 9'h004; rom[10'h011] = 9'h000; rom[10'h00C] = 9'h1FF;
    rom[10'h020] = 9'h1FF;
    for (int a = 16'h100; a < 16'h103; a++) rom[a] = 9'h000;
    for (int a = 16'h200; a < 16'h204; a++) rom[a] = 9'h001;
    rom[10'h204] = 9'h1FF;

    @(posedge Clk); #1;
    do_reset();

    // reset mid-run, then start at 0x040
    cycle(1, 10'h030, 0, 0);
    cycle(0, 10'h000, 0, 0);
    cycle(0, 10'h000, 0, 0);
    check("mid_run_pc", PC, 10'h032);
    do_reset();
    cycle(1, 10'h040, 0, 0);
    check("start_pc", PC, 10'h040);
    check("start_valid", Valid, 1);
    do_reset();

    // sequential wrap
    cycle(1, 10'h3FE, 0, 0);
    cycle(0, 10'h000, 0, 0);
    check("wrap_3ff", PC, 10'h3FF);
    cycle(0, 10'h000, 0, 0);
    check("wrap_000", PC, 10'h000);
    do_reset();

    // taken and not-taken branch
    cycle(1, 10'h010, 0, 0);
    cycle(0, 10'h000, 1, 1);
    check("br_taken", PC, 10'h00C);
    cycle(0, 10'h000, 0, 0);
    check("br_halt_done", Done, 1);
    cycle(1, 10'h010, 0, 0);
    cycle(0, 10'h000, 1, 0);
    check("br_not_taken", PC, 10'h011);
    do_reset();

    // halt beats taken branch, then restart and ignored Start
    cycle(1, 10'h020, 0, 0);
    cycle(0, 10'h000, 1, 1);
    check("halt_pc", PC, 10'h020);
    check("halt_done", Done, 1);
    check("halt_valid", Valid, 0);
    cycle(1, 10'h100, 0, 0);
    check("restart_done", Done, 0);
    check("restart_pc", PC, 10'h100);
    cycle(1, 10'h3AA, 0, 0);
    check("ignored_start_pc", PC, 10'h101);
    cycle(0, 10'h000, 0, 0);
    check("after_ignore_pc", PC, 10'h102);
    do_reset();

    // five-instruction program ending in halt
    cycle(1, 10'h200, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 10'h000, 0, 0);
    check("prog_done", Done, 1);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_five", CycleCount, 5);
    cycle(0, 10'h000, 0, 0);
    check("cnt_hold", CycleCount, 5);
    cycle(1, 10'h200, 0, 0);
    check("cnt_clear", CycleCount, 0);
`endif
    do_reset();

    // random programs
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle($urandom_range(0, 7) == 0, 10'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge Clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
